vga_tile_renderer: RTL

VGA_TILE_RENDERER -- requirements
Module: vga_tile_renderer

---
 rtl/vga_tile_renderer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/vga_tile_renderer.sv
// 640x480@60 VGA timing with a tile-grid renderer: tile codes fetched from external memory map through a 24-bit palette.
// Optional define VGA_GRID_LINES_EN overlays 0x404040 on the first row/column of every cell.
module vga_tile_renderer #(
  parameter int CLK_DIV    = 2,
  parameter int GRID_W     = 15,
  parameter int GRID_H     = 15,
  parameter int CELL_SHIFT = 5,
  parameter int X_OFFSET   = 80,
  parameter int Y_OFFSET   = 0,
  parameter int DATA_W     = 2,
  parameter int READ_LAT   = 1,
  localparam int CX_W      = (GRID_W > 1) ? $clog2(GRID_W) : 1,
  localparam int CY_W      = (GRID_H > 1) ? $clog2(GRID_H) : 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [CX_W-1:0]   cell_x,
  output logic [CY_W-1:0]   cell_y,
  output logic              cell_rd,
  input  logic [DATA_W-1:0] cell_data,
  input  logic              pal_we,
  input  logic [DATA_W-1:0] pal_addr,
  input  logic [23:0]       pal_wdata,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              hsync,
  output logic              vsync,
  output logic              pix_en,
  output logic              frame_start
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PAL_N = 1 << DATA_W;

  logic [DIV_W-1:0]    div_q, div_d;
  logic                pix_en_q, pix_en_d;
  logic [9:0]          hc_q, hc_d, vc_q, vc_d;
  logic [READ_LAT-1:0] grid_dly_q, act_dly_q, hs_dly_q, vs_dly_q;
  logic [23:0]         rgb_q, rgb_d;
  logic                hs_q, vs_q;
  logic [23:0]         pal_q [PAL_N];

  int   rel_x, rel_y;
  logic in_grid, active, hs_now, vs_now;

  function automatic logic [23:0] pal_init(int idx);
    case (idx)
      0:       return 24'h0000FF;
      1:       return 24'hFF0000;
      2:       return 24'h00FF00;
      default: return 24'hFF0000;
    endcase
  endfunction

  always_comb begin
    div_d    = div_q + DIV_W'(1);
    pix_en_d = 1'b0;
    if (div_q == DIV_W'(CLK_DIV - 1)) begin
      div_d    = '0;
      pix_en_d = 1'b1;
    end
    hc_d = hc_q;
    vc_d = vc_q;
    if (pix_en_q) begin
      if (hc_q == 10'd799) begin
        hc_d = '0;
        vc_d = (vc_q == 10'd524) ? '0 : vc_q + 10'd1;
      end else begin
        hc_d = hc_q + 10'd1;
      end
    end
  end

  // Address generation is gated by reset so the memory sees no reads while held.
  assign rel_x   = int'(hc_q) - X_OFFSET;
  assign rel_y   = int'(vc_q) - Y_OFFSET;
  assign in_grid = reset && (rel_x >= 0) && (rel_x < (GRID_W << CELL_SHIFT))
                         && (rel_y >= 0) && (rel_y < (GRID_H << CELL_SHIFT));
  assign active  = (hc_q < 10'd640) && (vc_q < 10'd480);
  assign hs_now  = !((hc_q >= 10'd656) && (hc_q < 10'd752));
  assign vs_now  = !((vc_q >= 10'd490) && (vc_q < 10'd492));

  assign cell_rd = in_grid;
  assign cell_x  = in_grid ? CX_W'(rel_x >> CELL_SHIFT) : '0;
  assign cell_y  = in_grid ? CY_W'(rel_y >> CELL_SHIFT) : '0;

`ifdef VGA_GRID_LINES_EN
  localparam int CELL_MASK = (1 << CELL_SHIFT) - 1;
  logic                on_line;
  logic [READ_LAT-1:0] line_dly_q;
  assign on_line = ((rel_x & CELL_MASK) == 0) || ((rel_y & CELL_MASK) == 0);
`endif

  always_comb begin
    rgb_d = '0;
    if (grid_dly_q[READ_LAT-1] && act_dly_q[READ_LAT-1]) begin
      rgb_d = pal_q[cell_data];
`ifdef VGA_GRID_LINES_EN
      if (line_dly_q[READ_LAT-1]) rgb_d = 24'h404040;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q      <= '0;
      pix_en_q   <= 1'b0;
      hc_q       <= '0;
      vc_q       <= '0;
      grid_dly_q <= '0;
      act_dly_q  <= '0;
      hs_dly_q   <= '1;
      vs_dly_q   <= '1;
      rgb_q      <= '0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
`ifdef VGA_GRID_LINES_EN
      line_dly_q <= '0;
`endif
      for (int i = 0; i < PAL_N; i++) pal_q[i] <= pal_init(i);
    end else begin
      div_q    <= div_d;
      pix_en_q <= pix_en_d;
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      // Palette writes ignore pix_en; a same-clk pixel read sees the old entry.
      if (pal_we) pal_q[pal_addr] <= pal_wdata;
      if (pix_en_q) begin
        grid_dly_q <= READ_LAT'({grid_dly_q, in_grid});
        act_dly_q  <= READ_LAT'({act_dly_q, active});
        hs_dly_q   <= READ_LAT'({hs_dly_q, hs_now});
        vs_dly_q   <= READ_LAT'({vs_dly_q, vs_now});
`ifdef VGA_GRID_LINES_EN
        line_dly_q <= READ_LAT'({line_dly_q, on_line});
`endif
        rgb_q <= rgb_d;
        hs_q  <= hs_dly_q[READ_LAT-1];
        vs_q  <= vs_dly_q[READ_LAT-1];
      end
    end
  end

  assign {red, green, blue} = rgb_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign pix_en      = pix_en_q;
  assign frame_start = pix_en_q && (hc_q == 10'd0) && (vc_q == 10'd0);

endmodule
